// File: rtl/cnn_pkg.sv
// Shared constants and types for the classifier decision stages.
// Holds the class/vote sizing, the vote vector type and the argmax FSM state encoding.
package cnn_pkg;

  localparam int NUM_CLASSES = 11;
  localparam int COUNT_W     = 8;
  localparam int IDX_W       = $clog2(NUM_CLASSES);

  typedef logic [COUNT_W-1:0] vote_t;
  typedef vote_t              vote_vec_t [NUM_CLASSES];
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } vote_state_t;

endpackage

// File: rtl/vote_cmp.sv
// One argmax step: folds a candidate (index, count) into the running best.
// Runner-up tracking ports exist only when VOTE_MARGIN_EN is defined.
module vote_cmp
  import cnn_pkg::*;
(
  input  idx_t  best_idx,
  input  vote_t best_cnt,
`ifdef VOTE_MARGIN_EN
  input  vote_t runner_cnt,
`endif
  input  idx_t  cand_idx,
  input  vote_t cand_cnt,
  output idx_t  new_idx,
  output vote_t new_cnt
`ifdef VOTE_MARGIN_EN
  ,
  output vote_t new_runner
`endif
);

  logic take;

  always_comb begin
    // Strictly greater only: equal counts keep the earlier (lower) index.
    take    = (cand_cnt > best_cnt);
    new_idx = take ? cand_idx : best_idx;
    new_cnt = take ? cand_cnt : best_cnt;
`ifdef VOTE_MARGIN_EN
    if (take) begin
      new_runner = best_cnt;
    end else if (cand_cnt > runner_cnt) begin
      new_runner = cand_cnt;
    end else begin
      new_runner = runner_cnt;
    end
`endif
  end

endmodule

// File: rtl/vote_argmax.sv
// Sequential argmax over the snapshotted class vote counts, one class per clock.
// Optional runner-up margin output is built when VOTE_MARGIN_EN is defined.
module vote_argmax
  import cnn_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  vote_vec_t   pred_in,
  output logic        busy,
  output logic        done,
  output idx_t        class_idx,
  output vote_t       class_count,
  output logic        no_vote,
  output vote_t       margin,
  output vote_state_t state_dbg
);

  // Handshake: go is a request sampled only while IDLE (ignored otherwise, never queued);
  // busy is high for the whole scan and done pulses for one cycle when the result
  // outputs take their new values, which then hold until the next done or reset.

  vote_state_t state, state_nxt;
  vote_vec_t   snap;
  idx_t        scan_idx;
  idx_t        best_idx;
  vote_t       best_cnt;
  idx_t        step_idx;
  vote_t       step_cnt;
  logic        last_step;

`ifdef VOTE_MARGIN_EN
  vote_t runner_cnt;
  vote_t step_runner;
`endif

  assign last_step = (scan_idx == idx_t'(NUM_CLASSES - 1));
  assign busy      = (state == SCAN);
  assign done      = (state == DONE);
  assign state_dbg = state;

  vote_cmp u_cmp (
    .best_idx   (best_idx),
    .best_cnt   (best_cnt),
`ifdef VOTE_MARGIN_EN
    .runner_cnt (runner_cnt),
`endif
    .cand_idx   (scan_idx),
    .cand_cnt   (snap[scan_idx]),
    .new_idx    (step_idx),
    .new_cnt    (step_cnt)
`ifdef VOTE_MARGIN_EN
    ,
    .new_runner (step_runner)
`endif
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = SCAN;
      SCAN:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      scan_idx    <= '0;
      best_idx    <= '0;
      best_cnt    <= '0;
      class_idx   <= '0;
      class_count <= '0;
      no_vote     <= 1'b1;
`ifdef VOTE_MARGIN_EN
      runner_cnt  <= '0;
      margin      <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (go) begin
            // Class 0 seeds the best, so the scan starts at index 1.
            snap       <= pred_in;
            best_idx   <= '0;
            best_cnt   <= pred_in[0];
            scan_idx   <= idx_t'(1);
`ifdef VOTE_MARGIN_EN
            runner_cnt <= '0;
`endif
          end
        end
        SCAN: begin
          best_idx   <= step_idx;
          best_cnt   <= step_cnt;
          scan_idx   <= scan_idx + idx_t'(1);
`ifdef VOTE_MARGIN_EN
          runner_cnt <= step_runner;
`endif
          if (last_step) begin
            class_idx   <= step_idx;
            class_count <= step_cnt;
            no_vote     <= (step_cnt == '0);
`ifdef VOTE_MARGIN_EN
            margin      <= step_cnt - step_runner;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifndef VOTE_MARGIN_EN
  assign margin = '0;
`endif

endmodule

// File: tb/tb_vote_argmax.sv
// Randomized scoreboard bench for vote_argmax against a sort-based reference model.
// Expected margin follows VOTE_MARGIN_EN, matching the build of the design.
module tb_vote_argmax;
  import cnn_pkg::*;

  localparam int W = IDX_W + 2 * COUNT_W + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        go    = 1'b0;
  vote_vec_t   pred_in;
  logic        busy, done, no_vote;
  idx_t        class_idx;
  vote_t       class_count, margin;
  vote_state_t state_dbg;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic [W-1:0] held;
  int           cyc    = 0;
  int           n_chk  = 0;
  int           n_fail = 0;

  vote_argmax dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .pred_in     (pred_in),
    .busy        (busy),
    .done        (done),
    .class_idx   (class_idx),
    .class_count (class_count),
    .no_vote     (no_vote),
    .margin      (margin),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input vote_vec_t v);
    int q[$];
    int best;
    int mrg;
    best = 0;
    for (int j = 0; j < NUM_CLASSES; j++) begin
      q.push_back(int'(v[j]));
      if (v[j] > v[best]) best = j;
    end
    q.rsort();
`ifdef VOTE_MARGIN_EN
    mrg = q[0] - q[1];
`else
    mrg = 0;
`endif
    return {idx_t'(best), vote_t'(q[0]), (q[0] == 0), vote_t'(mrg)};
  endfunction

  function automatic logic [W-1:0] reset_word();
    return {idx_t'(0), vote_t'(0), 1'b1, vote_t'(0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_vec(output vote_vec_t v, input int hi);
    for (int j = 0; j < NUM_CLASSES; j++) v[j] = vote_t'($urandom_range(0, hi));
  endtask

  // Call at a negedge: presents counts and go ahead of the next rising edge.
  task automatic start_scan(input vote_vec_t v);
    pred_in = v;
    go      = 1'b1;
    exp_q.push_back(model(v));
    due_q.push_back(cyc + NUM_CLASSES);
  endtask

  // Steps to the negedge after the DONE->IDLE edge, where a new go is legal.
  task automatic run_body(input bit noisy, input bit hold_go);
    vote_vec_t v;
    for (int i = 0; i <= NUM_CLASSES; i++) begin
      @(negedge clock);
      if (noisy) begin
        rand_vec(v, 255);
        pred_in = v;
        go = 1'($urandom_range(0, 1));
      end else begin
        go = 1'b0;
      end
      if (hold_go) go = 1'b1;
      if (i == NUM_CLASSES) go = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    vote_vec_t v;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      go = 1'b0;
      rand_vec(v, 255);
      pred_in = v;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    chk({tag, "_result"}, 32'({class_idx, class_count, no_vote, margin}), 32'(reset_word()));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    int d;
    held = reset_word();
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("spurious_done", 32'(done), 0);
          end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(d));
            chk("busy_at_done", 32'(busy), 0);
            chk("class_idx", 32'(class_idx), 32'(e[W-1 -: IDX_W]));
            chk("class_count", 32'(class_count), 32'(e[2*COUNT_W : COUNT_W+1]));
            chk("no_vote", 32'(no_vote), 32'(e[COUNT_W]));
            chk("margin", 32'(margin), 32'(e[COUNT_W-1:0]));
            held = e;
          end
        end else begin
          chk("result_hold", 32'({class_idx, class_count, no_vote, margin}), 32'(held));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vote_vec_t v;
    int budget;
    for (int j = 0; j < NUM_CLASSES; j++) pred_in[j] = '0;
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b0;
    idle(2);

    // Clear winner at class 1.
    v = '{8'd7, 8'd54, 8'd8, 8'd2, 8'd11, 8'd23, 8'd5, 8'd13, 8'd7, 8'd14, 8'd6};
    start_scan(v);
    @(negedge clock);
    chk("busy_after_go", 32'(busy), 1);
    go = 1'b0;
    for (int i = 1; i <= NUM_CLASSES; i++) @(negedge clock);
    idle(1);

    // Tie between classes 3 and 9 resolves to 3.
    for (int j = 0; j < NUM_CLASSES; j++) v[j] = 8'd5;
    v[3] = 8'd20;
    v[9] = 8'd20;
    start_scan(v);
    run_body(1'b0, 1'b0);

    // All zero votes.
    for (int j = 0; j < NUM_CLASSES; j++) v[j] = 8'd0;
    start_scan(v);
    run_body(1'b0, 1'b0);

    // Maximum value in the last class.
    for (int j = 0; j < NUM_CLASSES; j++) v[j] = 8'd254;
    v[NUM_CLASSES-1] = 8'd255;
    start_scan(v);
    run_body(1'b0, 1'b0);
    idle(2);

    // go held high across two back-to-back scans with pred_in churning mid-scan.
    rand_vec(v, 255);
    start_scan(v);
    run_body(1'b1, 1'b1);
    rand_vec(v, 255);
    start_scan(v);
    run_body(1'b1, 1'b1);
    idle(3);

    // Reset on the 5th SCAN cycle discards the partial scan.
    rand_vec(v, 255);
    start_scan(v);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      go = 1'b0;
    end
    reset = 1'b1;
    exp_q.delete();
    due_q.delete();
    held = reset_word();
    @(negedge clock);
    chk_reset_outputs("midscan_reset");
    reset = 1'b0;
    idle(2);
    rand_vec(v, 255);
    start_scan(v);
    run_body(1'b0, 1'b0);

    // Randomized scans: narrow ranges force ties, noisy go during the scan is ignored.
    for (int n = 0; n < 40; n++) begin
      rand_vec(v, (n % 3 == 0) ? 3 : ((n % 3 == 1) ? 40 : 255));
      start_scan(v);
      run_body(1'($urandom_range(0, 1)), 1'b0);
      idle($urandom_range(0, 3));
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 4 * NUM_CLASSES) begin
      @(negedge clock);
      budget++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
